seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter_pkg.sv | 32 +++
 rtl/seq_shifter_if.sv | 29 ++
 rtl/seq_shifter_shift_step.sv | 31 +++
 rtl/seq_shifter.sv | 103 ++++++++++
 tb/tb_seq_shifter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_shifter_pkg.sv
// Shared types for the sequential shifter: operation codes, FSM states, mode decode.
// SEQ_SHIFTER_ROTATE_EN enables the ROL/ROR codes; otherwise they decode as pass-through.
package seq_shifter_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        SH_SLL = 3'd0,
        SH_SRL = 3'd1,
        SH_SRA = 3'd2,
        SH_ROL = 3'd3,
        SH_ROR = 3'd4
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    // True when the code moves bits; everything else finishes in one cycle unchanged.
    function automatic logic is_shift(input logic [MODE_W-1:0] m);
        case (m)
            SH_SLL, SH_SRL, SH_SRA: is_shift = 1'b1;
`ifdef SEQ_SHIFTER_ROTATE_EN
            SH_ROL, SH_ROR:         is_shift = 1'b1;
`endif
            default:                is_shift = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// Request/response bundle between a client (master) and the sequential shifter (slave).
interface seq_shifter_if
    import seq_shifter_pkg::*;
#(
    parameter int XLEN = 32
);
    localparam int SW = $clog2(XLEN);

    logic              start;
    logic [MODE_W-1:0] mode;
    logic [XLEN-1:0]   operand;
    logic [SW-1:0]     shamt;
    logic              flush;
    logic              ready;
    logic              busy;
    logic              done;
    logic [XLEN-1:0]   result;

    modport master (
        output start, mode, operand, shamt, flush,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, mode, operand, shamt, flush,
        output ready, busy, done, result
    );

endinterface

// File: rtl/seq_shifter_shift_step.sv
// Combinational single step of the shifter: moves data by 0..STEP bits in the given mode.
// Wrap paths exist only when SEQ_SHIFTER_ROTATE_EN is defined.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1,
    localparam int AW  = $clog2(STEP + 1)
) (
    input  logic [MODE_W-1:0] mode_i,
    input  logic [XLEN-1:0]   data_i,
    input  logic [AW-1:0]     amt_i,
    output logic [XLEN-1:0]   data_o
);

    always_comb begin
        data_o = data_i;
        case (mode_i)
            SH_SLL: data_o = data_i << amt_i;
            SH_SRL: data_o = data_i >> amt_i;
            SH_SRA: data_o = $unsigned($signed(data_i) >>> amt_i);
`ifdef SEQ_SHIFTER_ROTATE_EN
            // amt_i == 0 gives a shift by XLEN on the wrap side, which yields zero
            SH_ROL: data_o = (data_i << amt_i) | (data_i >> (XLEN - int'(amt_i)));
            SH_ROR: data_o = (data_i >> amt_i) | (data_i << (XLEN - int'(amt_i)));
`endif
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: shifts by up to STEP bits per cycle until the requested distance is done.
// Define SEQ_SHIFTER_ROTATE_EN to add ROL/ROR; without it those codes pass the operand through.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         reset,
    seq_shifter_if.slave bus
);

    localparam int SW = $clog2(XLEN);
    localparam int AW = $clog2(STEP + 1);
    localparam logic [SW:0] STEP_W = STEP[SW:0];

    generate
        if (STEP < 1 || STEP > XLEN || (STEP & (STEP - 1)) != 0) begin : g_bad_step
            $error("seq_shifter: STEP=%0d must be a power of two in 1..%0d", STEP, XLEN);
        end
    endgenerate

    state_e            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [SW-1:0]     rem_q, rem_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [AW-1:0]     step_amt;
    logic [XLEN-1:0]   step_out;
    logic              ready;

    assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // Last step may be shorter than STEP; the else branch only sees rem_q <= STEP.
    always_comb begin
        step_amt = AW'(rem_q);
        if ({1'b0, rem_q} > STEP_W) step_amt = AW'(STEP);
    end

    shift_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_step (
        .mode_i (mode_q),
        .data_i (result_q),
        .amt_i  (step_amt),
        .data_o (step_out)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rem_d    = rem_q;
        mode_d   = mode_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_d = ST_IDLE;
                    if (bus.start) begin
                        result_d = bus.operand;
                        mode_d   = bus.mode;
                        rem_d    = bus.shamt;
                        if (bus.shamt == '0 || !is_shift(bus.mode)) begin
                            state_d = ST_DONE;
                            rem_d   = '0;
                        end else begin
                            state_d = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    result_d = step_out;
                    rem_d    = rem_q - SW'(step_amt);
                    if (rem_d == '0) state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            rem_q    <= '0;
            mode_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            mode_q   <= mode_d;
        end
    end

    assign bus.ready  = ready;
    assign bus.busy   = (state_q == ST_BUSY);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: STEP=1 and STEP=4 instances, vector table plus corner sequences.
module tb_seq_shifter;
    import seq_shifter_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    seq_shifter_if #(.XLEN(32)) bus_a ();
    seq_shifter_if #(.XLEN(32)) bus_b ();

    seq_shifter #(.XLEN(32), .STEP(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    seq_shifter #(.XLEN(32), .STEP(4)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          use_b;
        logic [2:0]  mode;
        logic [31:0] op;
        logic [4:0]  sh;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit use_b, input logic st, input logic [2:0] m,
                          input logic [31:0] op, input logic [4:0] sh);
        if (use_b) begin
            bus_b.start = st; bus_b.mode = m; bus_b.operand = op; bus_b.shamt = sh;
        end else begin
            bus_a.start = st; bus_a.mode = m; bus_a.operand = op; bus_a.shamt = sh;
        end
    endtask

    // Called just after a rising edge; lat counts cycles from the accept edge to done.
    task automatic run_op(input bit use_b, input logic [2:0] m, input logic [31:0] op,
                          input logic [4:0] sh, output logic [31:0] res, output int lat);
        set_in(use_b, 1'b1, m, op, sh);
        @(posedge clk); #1;
        set_in(use_b, 1'b0, m, op, sh);
        lat = -1;
        res = 'x;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if ((use_b ? bus_b.done : bus_a.done) === 1'b1) begin
                lat = c;
                res = use_b ? bus_b.result : bus_a.result;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        int          pulses;

        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b0, SH_SRA, 32'h8000_00F0, 5'd4,  32'hF800_000F, 5};
        vecs[1]  = '{1'b0, SH_SLL, 32'h1234_5678, 5'd0,  32'h1234_5678, 1};
        vecs[2]  = '{1'b0, 3'd7,   32'h1234_5678, 5'd5,  32'h1234_5678, 1};
        vecs[3]  = '{1'b1, SH_SRL, 32'hFFFF_FFFF, 5'd7,  32'h01FF_FFFF, 3};
        vecs[4]  = '{1'b0, SH_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 32};
        vecs[5]  = '{1'b0, SH_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 32};
        vecs[6]  = '{1'b1, SH_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9};
        vecs[7]  = '{1'b1, SH_SLL, 32'h0000_0001, 5'd4,  32'h0000_0010, 2};
        vecs[8]  = '{1'b1, 3'd5,   32'hCAFE_F00D, 5'd9,  32'hCAFE_F00D, 1};
        vecs[9]  = '{1'b1, SH_SRA, 32'h7000_0000, 5'd3,  32'h0E00_0000, 2};
`ifdef SEQ_SHIFTER_ROTATE_EN
        vecs[10] = '{1'b0, SH_ROL, 32'h8000_0001, 5'd1,  32'h0000_0003, 2};
        vecs[11] = '{1'b1, SH_ROR, 32'h0000_0011, 5'd5,  32'h8800_0000, 3};
`else
        vecs[10] = '{1'b0, SH_ROL, 32'h8000_0001, 5'd1,  32'h8000_0001, 1};
        vecs[11] = '{1'b1, SH_ROR, 32'h0000_0011, 5'd5,  32'h0000_0011, 1};
`endif

        reset = 1'b0;
        set_in(1'b0, 1'b0, 3'd0, 32'h0, 5'd0);
        set_in(1'b1, 1'b0, 3'd0, 32'h0, 5'd0);
        bus_a.flush = 1'b0;
        bus_b.flush = 1'b0;
        #1;
        chk("rst_ready", 32'(bus_a.ready), 32'd1);
        chk("rst_busy",  32'(bus_a.busy),  32'd0);
        chk("rst_done",  32'(bus_a.done),  32'd0);
        chk("rst_result", bus_a.result,    32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].use_b, vecs[i].mode, vecs[i].op, vecs[i].sh, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // start and input changes during BUSY are ignored (STEP=4)
        set_in(1'b1, 1'b1, SH_SRL, 32'hFFFF_FFFF, 5'd7);
        @(posedge clk); #1;
        set_in(1'b1, 1'b1, SH_SLL, 32'h0000_0000, 5'd3);
        @(negedge clk);
        chk("ign_busy1", 32'(bus_b.busy), 32'd1);
        @(posedge clk); #1;
        set_in(1'b1, 1'b0, SH_SLL, 32'h0000_0000, 5'd3);
        @(negedge clk);
        chk("ign_busy2", 32'(bus_b.busy), 32'd1);
        @(negedge clk);
        chk("ign_done",   32'(bus_b.done), 32'd1);
        chk("ign_result", bus_b.result,    32'h01FF_FFFF);
        @(posedge clk); #1;

        // flush two cycles into a 10-bit SLL: back to IDLE, result frozen, no done
        set_in(1'b0, 1'b1, SH_SLL, 32'h0000_0001, 5'd10);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, SH_SLL, 32'h0000_0001, 5'd10);
        @(posedge clk); #1;
        bus_a.flush = 1'b1;
        @(posedge clk); #1;
        bus_a.flush = 1'b0;
        @(negedge clk);
        chk("flush_ready",  32'(bus_a.ready), 32'd1);
        chk("flush_busy",   32'(bus_a.busy),  32'd0);
        chk("flush_result", bus_a.result,     32'h0000_0002);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) pulses++;
        end
        chk("flush_no_done", 32'(pulses), 32'd0);
        @(posedge clk); #1;

        // flush beats start in the same cycle
        set_in(1'b0, 1'b1, SH_SRL, 32'hFFFF_0000, 5'd0);
        bus_a.flush = 1'b1;
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, SH_SRL, 32'hFFFF_0000, 5'd0);
        bus_a.flush = 1'b0;
        @(negedge clk);
        chk("flstart_done",   32'(bus_a.done), 32'd0);
        chk("flstart_result", bus_a.result,    32'h0000_0002);
        @(posedge clk); #1;

        // asynchronous reset in the middle of BUSY
        set_in(1'b0, 1'b1, SH_SLL, 32'h0000_0001, 5'd10);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, SH_SLL, 32'h0000_0001, 5'd10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(bus_a.busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_ready",  32'(bus_a.ready), 32'd1);
        chk("arst_busy",   32'(bus_a.busy),  32'd0);
        chk("arst_done",   32'(bus_a.done),  32'd0);
        chk("arst_result", bus_a.result,     32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_op(1'b0, SH_SLL, 32'h0000_0001, 5'd2, res, lat);
        chk("post_rst_result",  res,      32'h0000_0004);
        chk("post_rst_latency", 32'(lat), 32'd3);

        // start held high across DONE: back-to-back accept, one done cycle each
        set_in(1'b0, 1'b1, SH_SLL, 32'h0000_0001, 5'd2);
        @(posedge clk); #1;
        set_in(1'b0, 1'b1, SH_SRL, 32'h0000_0080, 5'd1);
        @(negedge clk);
        chk("b2b_busy1", 32'(bus_a.busy), 32'd1);
        @(negedge clk);
        chk("b2b_busy2", 32'(bus_a.busy), 32'd1);
        @(negedge clk);
        chk("b2b_done1",   32'(bus_a.done), 32'd1);
        chk("b2b_result1", bus_a.result,    32'h0000_0004);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, SH_SRL, 32'h0000_0080, 5'd1);
        @(negedge clk);
        chk("b2b_gap_done", 32'(bus_a.done), 32'd0);
        chk("b2b_gap_busy", 32'(bus_a.busy), 32'd1);
        @(negedge clk);
        chk("b2b_done2",   32'(bus_a.done), 32'd1);
        chk("b2b_result2", bus_a.result,    32'h0000_0040);
        @(negedge clk);
        chk("b2b_idle_done",  32'(bus_a.done),  32'd0);
        chk("b2b_idle_ready", 32'(bus_a.ready), 32'd1);
        chk("b2b_hold",       bus_a.result,     32'h0000_0040);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
